// File: rtl/inst_rom_responder_if.sv
// Instruction-fetch request/response bundle between the fetch unit (master)
// and the instruction ROM responder (slave).
interface inst_rom_responder_if;
    logic        REQ;
    logic [31:0] ADDR;
    logic        ACK;
    logic [31:0] INST;
    logic        ERR;

    modport master (
        output REQ,
        output ADDR,
        input  ACK,
        input  INST,
        input  ERR
    );

    modport slave (
        input  REQ,
        input  ADDR,
        output ACK,
        output INST,
        output ERR
    );
endinterface

// File: rtl/inst_rom_responder.sv
// Instruction ROM responder with programmable wait states and a program-load port.
// Define INST_ROM_PREFETCH_EN to add a one-entry next-line prefetch buffer.
module inst_rom_responder #(
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    inst_rom_responder_if.slave   bus,
    input  logic                  LD_EN,
    input  logic [31:0]           LD_ADDR,
    input  logic [31:0]           LD_DATA
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned IDX_W = DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        addr_q, addr_d;
    logic               ack_q, ack_d;
    logic [31:0]        inst_q, inst_d;
    logic               err_q, err_d;
    logic               load_rsp;

    logic [31:0]        mem_q [DEPTH];

    logic [31:0]        rd_addr_c;
    logic [IDX_W-1:0]   rd_idx_c;
    logic               rd_bad_c;
    logic [IDX_W-1:0]   ld_idx_c;
    logic               ld_we_c;
    logic               pf_hit_c;
    logic [31:0]        pf_data_c;

    // Misaligned or beyond the array: the address cannot name a word.
    function automatic logic addr_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:DEPTH_LOG2+2] != '0);
    endfunction

    // In IDLE the read address comes straight from the bus (zero-wait and hit paths).
    assign rd_addr_c = (state_q == S_IDLE) ? bus.ADDR : addr_q;
    assign rd_idx_c  = rd_addr_c[DEPTH_LOG2+1:2];
    assign rd_bad_c  = addr_bad(rd_addr_c);

    assign ld_idx_c  = LD_ADDR[DEPTH_LOG2+1:2];
    assign ld_we_c   = LD_EN && !RST && !addr_bad(LD_ADDR);

    always_ff @(posedge CLK) begin
        if (ld_we_c) begin
            mem_q[ld_idx_c] <= LD_DATA;
        end
    end

`ifdef INST_ROM_PREFETCH_EN
    logic               pf_valid_q;
    logic [IDX_W-1:0]   pf_tag_q;
    logic [31:0]        pf_data_q;
    logic [IDX_W-1:0]   rsp_idx_q;
    logic [IDX_W:0]     nxt_c;
    logic               nxt_ok_c;

    assign nxt_c     = {1'b0, rsp_idx_q} + (IDX_W+1)'(1);
    assign nxt_ok_c  = !nxt_c[IDX_W];
    assign pf_hit_c  = (state_q == S_IDLE) && bus.REQ && pf_valid_q &&
                       !addr_bad(bus.ADDR) && (bus.ADDR[DEPTH_LOG2+1:2] == pf_tag_q);
    assign pf_data_c = pf_data_q;

    // Fill w+1 on the edge after a clean ACK; a load to the tracked word kills the entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            pf_valid_q <= 1'b0;
            rsp_idx_q  <= '0;
        end else begin
            if (load_rsp) begin
                rsp_idx_q <= rd_idx_c;
            end
            if (ld_we_c && (ld_idx_c == pf_tag_q)) begin
                pf_valid_q <= 1'b0;
            end
            if ((state_q == S_RESP) && !err_q && nxt_ok_c) begin
                pf_tag_q   <= nxt_c[IDX_W-1:0];
                pf_data_q  <= mem_q[nxt_c[IDX_W-1:0]];
                pf_valid_q <= !(ld_we_c && (ld_idx_c == nxt_c[IDX_W-1:0]));
            end
        end
    end
`else
    assign pf_hit_c  = 1'b0;
    assign pf_data_c = '0;
`endif

    // Next-state and response logic; the array is read on the edge entering RESP.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        ack_d    = 1'b0;
        inst_d   = inst_q;
        err_d    = err_q;
        load_rsp = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.REQ) begin
                    addr_d = bus.ADDR;
                    if (pf_hit_c || (WAIT_CYCLES == 0)) begin
                        state_d  = S_RESP;
                        load_rsp = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            S_WAIT: begin
                if (!bus.REQ) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d  = S_RESP;
                    load_rsp = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_rsp) begin
            ack_d = 1'b1;
            if (pf_hit_c) begin
                inst_d = pf_data_c;
                err_d  = 1'b0;
            end else begin
                inst_d = rd_bad_c ? 32'h0 : mem_q[rd_idx_c];
                err_d  = rd_bad_c;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            ack_q   <= ack_d;
            inst_q  <= inst_d;
            err_q   <= err_d;
        end
    end

    assign bus.ACK  = ack_q;
    assign bus.INST = inst_q;
    assign bus.ERR  = err_q;

endmodule

// File: tb/tb_inst_rom_responder.sv
// Bench for inst_rom_responder: directed protocol cases plus random traffic
// checked against an array model of the ROM and its access timing.
module tb_inst_rom_responder;

    localparam int unsigned DL    = 6;
    localparam int unsigned WC    = 2;
    localparam int unsigned DEPTH = 1 << DL;

    logic        CLK = 1'b0;
    logic        RST;
    logic        LD_EN;
    logic [31:0] LD_ADDR;
    logic [31:0] LD_DATA;

    always #5 CLK = ~CLK;

    inst_rom_responder_if bus_a ();
    inst_rom_responder_if bus_b ();

    inst_rom_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(WC)) dut_a (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus_a),
        .LD_EN   (LD_EN),
        .LD_ADDR (LD_ADDR),
        .LD_DATA (LD_DATA)
    );

    inst_rom_responder #(.DEPTH_LOG2(DL), .WAIT_CYCLES(0)) dut_b (
        .CLK     (CLK),
        .RST     (RST),
        .bus     (bus_b),
        .LD_EN   (LD_EN),
        .LD_ADDR (LD_ADDR),
        .LD_DATA (LD_DATA)
    );

    logic [31:0] mem_m [DEPTH];
    bit          pf_v;
    int          pf_tag;
    int          n_pass;
    int          n_fail;
    int          n_total;
    logic [31:0] last_addr;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit m_bad(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:DL+2] != '0);
    endfunction

    function automatic int m_idx(input logic [31:0] a);
        return int'(a[DL+1:2]);
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        LD_EN   = 1'b1;
        LD_ADDR = a;
        LD_DATA = d;
        tick();
        LD_EN   = 1'b0;
        if (!m_bad(a)) begin
            mem_m[m_idx(a)] = d;
            if (pf_v && (pf_tag == m_idx(a))) pf_v = 1'b0;
        end
    endtask

    task automatic do_reset;
        RST       = 1'b1;
        bus_a.REQ = 1'b0;
        bus_b.REQ = 1'b0;
        tick();
        tick();
        RST  = 1'b0;
        pf_v = 1'b0;
    endtask

    // One read on dut_a: expected data, error flag and latency come from the model.
    task automatic do_read(input string tag, input logic [31:0] a);
        bit          bad;
        logic [31:0] exp_inst;
        int          exp_lat;
        int          n;
        bit          got;
        bad      = m_bad(a);
        exp_inst = bad ? 32'h0 : mem_m[m_idx(a)];
        exp_lat  = WC + 1;
`ifdef INST_ROM_PREFETCH_EN
        if (pf_v && !bad && (m_idx(a) == pf_tag)) exp_lat = 1;
`endif
        bus_a.REQ  = 1'b1;
        bus_a.ADDR = a;
        n   = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            tick();
            n++;
            if (bus_a.ACK === 1'b1) got = 1'b1;
        end
        check({tag, "/ack"}, 32'(got), 32'd1);
        check({tag, "/lat"}, 32'(n), 32'(exp_lat));
        check({tag, "/inst"}, bus_a.INST, exp_inst);
        check({tag, "/err"}, 32'(bus_a.ERR), 32'(bad));
        bus_a.REQ = 1'b0;
        tick();
        check({tag, "/ackpulse"}, 32'(bus_a.ACK), 32'd0);
        check({tag, "/hold"}, bus_a.INST, exp_inst);
        if (!bad && (m_idx(a) + 1 < int'(DEPTH))) begin
            pf_v   = 1'b1;
            pf_tag = m_idx(a) + 1;
        end
        last_addr = a;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old_w;
        logic [31:0] ra;
        n_pass     = 0;
        n_fail     = 0;
        n_total    = 0;
        pf_v       = 1'b0;
        pf_tag     = 0;
        last_addr  = 32'h0;
        LD_EN      = 1'b0;
        LD_ADDR    = 32'h0;
        LD_DATA    = 32'h0;
        bus_a.ADDR = 32'h0;
        bus_b.ADDR = 32'h0;
        do_reset();

        // Fill the array, then reset: contents must survive reset.
        for (int i = 0; i < int'(DEPTH); i++) load(32'(i * 4), $urandom | 32'h1);
        load(32'h0, 32'h2002_0005);
        do_reset();
        check("rst/ack_a", 32'(bus_a.ACK), 32'd0);
        check("rst/inst_a", bus_a.INST, 32'h0);
        check("rst/err_a", 32'(bus_a.ERR), 32'd0);
        check("rst/ack_b", 32'(bus_b.ACK), 32'd0);

        do_read("word0", 32'h0000_0000);
        do_read("misalign", 32'h0000_0102);
        do_read("oor", 32'h0000_0100);
        do_read("lastword", 32'h0000_00FC);

        // Abort in WAIT: no ACK, then a full-latency retry.
        do_reset();
        bus_a.REQ  = 1'b1;
        bus_a.ADDR = 32'h4;
        tick();
        bus_a.REQ = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort/noack", 32'(bus_a.ACK), 32'd0);
        end
        do_read("abort/retry", 32'h4);

        // Load to word 3 on the edge entering RESP returns the old word.
        do_reset();
        old_w      = mem_m[3];
        bus_a.REQ  = 1'b1;
        bus_a.ADDR = 32'hC;
        tick();
        tick();
        check("rbw/early", 32'(bus_a.ACK), 32'd0);
        LD_EN   = 1'b1;
        LD_ADDR = 32'hC;
        LD_DATA = 32'hAAAA_5555;
        tick();
        LD_EN = 1'b0;
        check("rbw/ack", 32'(bus_a.ACK), 32'd1);
        check("rbw/old", bus_a.INST, old_w);
        mem_m[3]  = 32'hAAAA_5555;
        bus_a.REQ = 1'b0;
        tick();
        pf_v   = 1'b1;
        pf_tag = 4;
        do_read("rbw/reread", 32'hC);

        // Reset during WAIT abandons the request and clears outputs.
        do_read("pre_rst", 32'h8);
        bus_a.REQ  = 1'b1;
        bus_a.ADDR = 32'h14;
        tick();
        RST = 1'b1;
        tick();
        check("rstwait/ack", 32'(bus_a.ACK), 32'd0);
        check("rstwait/inst", bus_a.INST, 32'h0);
        check("rstwait/err", 32'(bus_a.ERR), 32'd0);
        RST       = 1'b0;
        bus_a.REQ = 1'b0;
        pf_v      = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rstwait/noack", 32'(bus_a.ACK), 32'd0);
        end

        // Zero-wait instance: ACK one cycle after the request.
        bus_b.REQ  = 1'b1;
        bus_b.ADDR = 32'h14;
        tick();
        check("w0/ack", 32'(bus_b.ACK), 32'd1);
        check("w0/inst", bus_b.INST, mem_m[5]);
        check("w0/err", 32'(bus_b.ERR), 32'd0);
        bus_b.ADDR = 32'h3;
        tick();
        check("w0/pulse", 32'(bus_b.ACK), 32'd0);
        tick();
        check("w0/err_ack", 32'(bus_b.ACK), 32'd1);
        check("w0/err_inst", bus_b.INST, 32'h0);
        check("w0/err_flag", 32'(bus_b.ERR), 32'd1);
        bus_b.REQ = 1'b0;
        tick();

        // Sequential reads and a load into the next line.
        do_reset();
        do_read("seq8", 32'h8);
        do_read("seqC", 32'hC);
        load(32'h10, 32'h1234_5678);
        do_read("seq10", 32'h10);

        // Random traffic, including dropped loads and error addresses.
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 7))
                0: load(32'($urandom_range(0, DEPTH - 1)) << 2, $urandom);
                1: load($urandom, $urandom);
                2: do_read("rnd/seq", m_bad(last_addr) ? 32'h0 : (last_addr + 32'h4) & 32'h0000_00FC);
                3: do_read("rnd/mis", (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3)));
                4: do_read("rnd/oor", ($urandom << 2) | 32'h0000_0100);
                default: begin
                    ra = 32'($urandom_range(0, DEPTH - 1)) << 2;
                    do_read("rnd/any", ra);
                end
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
